// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS controller and the ula.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // ALUOP_NONE parks the ula on code 0 in states that do not use it.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ULA_AND = 3'd0;
    localparam logic [2:0] ULA_OR  = 3'd1;
    localparam logic [2:0] ULA_ADD = 3'd2;
    localparam logic [2:0] ULA_NOR = 3'd3;
    localparam logic [2:0] ULA_SUB = 3'd6;
    localparam logic [2:0] ULA_SLT = 3'd7;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; the controller uses the slave modport.
interface multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Z;
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ULAControl;
    logic [3:0] Estado;

    modport slave (
        input  Op, Funct, Z,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ULAControl, Estado
    );

    modport master (
        output Op, Funct, Z,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ULAControl, Estado
    );
endinterface

// File: rtl/multicycle_ctrl_ula_decoder.sv
// Combinational ALUOp + Funct -> ULAControl map.
module ula_decoder
    import multicycle_pkg::*;
(
    input  aluop_t     i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_ula_control
);
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_ula_control = ULA_AND;
        unique case (i_alu_op)
            ALUOP_ADD:   o_ula_control = ULA_ADD;
            ALUOP_SUB:   o_ula_control = ULA_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_AND: o_ula_control = ULA_AND;
                    FUNCT_OR:  o_ula_control = ULA_OR;
                    FUNCT_ADD: o_ula_control = ULA_ADD;
                    FUNCT_NOR: o_ula_control = ULA_NOR;
                    FUNCT_SUB: o_ula_control = ULA_SUB;
                    FUNCT_SLT: o_ula_control = ULA_SLT;
                    default:   o_ula_control = ULA_ADD;
                endcase
            end
            ALUOP_NONE:  o_ula_control = ULA_AND;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional bne support is enabled by defining CTRL_BNE_EN.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);
    state_t r_state;
    state_t w_next;
    state_t w_dec_state;
    aluop_t w_alu_op;
    logic   w_pc_write, w_branch, w_cond;
    logic   w_mem_write, w_ir_write, w_reg_write;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for registered state so every flop samples pre-edge values.
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
`ifdef CTRL_BNE_EN
                    OP_BNE:       w_next = S_BRANCH;
`endif
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // While in reset the selects show FETCH decoding; enables are masked below.
    assign w_dec_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_pc_write     = 1'b0;
        w_branch       = 1'b0;
        w_mem_write    = 1'b0;
        w_ir_write     = 1'b0;
        w_reg_write    = 1'b0;
        bus.IorD       = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        w_alu_op       = ALUOP_NONE;
        case (w_dec_state)
            S_FETCH:    begin w_ir_write = 1'b1; w_pc_write = 1'b1; bus.ALUSrcB = 2'b01; w_alu_op = ALUOP_ADD; end
            S_DECODE:   begin bus.ALUSrcB = 2'b11; w_alu_op = ALUOP_ADD; end
            S_MEMADR:   begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; w_alu_op = ALUOP_ADD; end
            S_MEMREAD:  bus.IorD = 1'b1;
            S_MEMWB:    begin bus.MemtoReg = 1'b1; w_reg_write = 1'b1; end
            S_MEMWRITE: begin bus.IorD = 1'b1; w_mem_write = 1'b1; end
            S_EXECUTE:  begin bus.ALUSrcA = 1'b1; w_alu_op = ALUOP_FUNCT; end
            S_ALUWB:    begin bus.RegDst = 1'b1; w_reg_write = 1'b1; end
            S_BRANCH:   begin bus.ALUSrcA = 1'b1; bus.PCSrc = 2'b01; w_branch = 1'b1; w_alu_op = ALUOP_SUB; end
            S_ADDIEXEC: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; w_alu_op = ALUOP_ADD; end
            S_ADDIWB:   w_reg_write = 1'b1;
            S_JUMP:     begin bus.PCSrc = 2'b10; w_pc_write = 1'b1; end
            default:    ;
        endcase
    end

`ifdef CTRL_BNE_EN
    assign w_cond = (bus.Op == OP_BNE) ? ~bus.Z : bus.Z;
`else
    assign w_cond = bus.Z;
`endif

    assign bus.PCEn     = ~reset & (w_pc_write | (w_branch & w_cond));
    assign bus.MemWrite = ~reset & w_mem_write;
    assign bus.IRWrite  = ~reset & w_ir_write;
    assign bus.RegWrite = ~reset & w_reg_write;
    assign bus.Estado   = r_state;

    ula_decoder u_ula_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (bus.Funct),
        .o_ula_control (bus.ULAControl)
    );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   path_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

`ifdef CTRL_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    function automatic bit is_known(input logic [5:0] op);
        return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == J
               || (BNE_ON && op == BNE);
    endfunction

    // State sequence an instruction walks, FETCH through last state.
    function automatic void build_path(input logic [5:0] op);
        path_q = {0, 1};
        if (op == LW)                             path_q = {path_q, 2, 3, 4};
        else if (op == SW)                        path_q = {path_q, 2, 5};
        else if (op == RT)                        path_q = {path_q, 6, 7};
        else if (op == ADDI)                      path_q = {path_q, 9, 10};
        else if (op == BEQ || (BNE_ON && op == BNE)) path_q = {path_q, 8};
        else if (op == J)                         path_q = {path_q, 11};
    endfunction

    function automatic logic [2:0] funct_code(input logic [5:0] f);
        case (f)
            6'b100100: return 3'd0;
            6'b100101: return 3'd1;
            6'b100000: return 3'd2;
            6'b100111: return 3'd3;
            6'b100010: return 3'd6;
            6'b101010: return 3'd7;
            default:   return 3'd2;
        endcase
    endfunction

    // Packed {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ULAControl}.
    function automatic logic [14:0] exp_out(input int st, input logic [5:0] op,
                                            input logic [5:0] f, input logic z);
        logic pcen = 0, iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, srca = 0;
        logic [1:0] srcb = 0, pcsrc = 0;
        logic [2:0] ula = 0;
        case (st)
            0:  begin irw = 1; pcen = 1; srcb = 1; ula = 2; end
            1:  begin srcb = 3; ula = 2; end
            2:  begin srca = 1; srcb = 2; ula = 2; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srca = 1; ula = funct_code(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; ula = 6; pcsrc = 1; pcen = (op == BNE) ? ~z : z; end
            9:  begin srca = 1; srcb = 2; ula = 2; end
            10: rw = 1;
            11: begin pcsrc = 2; pcen = 1; end
            default: ;
        endcase
        return {pcen, iord, mw, irw, rd, m2r, rw, srca, srcb, pcsrc, ula};
    endfunction

    function automatic logic [14:0] outs();
        return {bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ULAControl};
    endfunction

    function automatic logic [3:0] enables();
        return {bus.PCEn, bus.MemWrite, bus.IRWrite, bus.RegWrite};
    endfunction

    // Called at a negedge with the FSM in FETCH; returns at the negedge after the last state.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input bit fix_z, input logic zval);
        build_path(op);
        bus.Op    = op;
        bus.Funct = f;
        foreach (path_q[i]) begin
            bus.Z = fix_z ? zval : 1'($urandom_range(0, 1));
            #1;
            check($sformatf("estado op=%b step=%0d", op, i), 32'(bus.Estado), 32'(path_q[i]));
            check($sformatf("outs op=%b f=%b st=%0d z=%b", op, f, path_q[i], bus.Z),
                  32'(outs()), 32'(exp_out(path_q[i], op, f, bus.Z)));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] op_tbl [0:7];
        logic [5:0] fn_tbl [0:5];
        op_tbl = '{LW, SW, RT, BEQ, ADDI, J, BNE, 6'b111111};
        fn_tbl = '{6'b100100, 6'b100101, 6'b100000, 6'b100111, 6'b100010, 6'b101010};

        reset = 1'b1;
        bus.Op = LW;
        bus.Funct = 6'd0;
        bus.Z = 1'b0;
        #1;
        check("reset_en_initial", 32'(enables()), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset_estado", 32'(bus.Estado), 32'd0);
            check("reset_outs", 32'(outs()), 32'(exp_out(0, LW, 6'd0, 1'b0) & 15'h3BFF & 15'h7FFF & ~15'h4000 & ~15'h0800));
        end
        reset = 1'b0;

        // Directed instructions covering each path and branch outcome.
        run_instr(LW, 6'd0, 1'b0, 1'b0);
        run_instr(RT, 6'b101010, 1'b0, 1'b0);
        run_instr(RT, 6'b100010, 1'b0, 1'b0);
        run_instr(RT, 6'b110011, 1'b0, 1'b0);
        run_instr(BEQ, 6'd0, 1'b1, 1'b1);
        run_instr(BEQ, 6'd0, 1'b1, 1'b0);
        run_instr(SW, 6'd0, 1'b0, 1'b0);
        run_instr(J, 6'd0, 1'b0, 1'b0);
        run_instr(ADDI, 6'd0, 1'b0, 1'b0);
        run_instr(BNE, 6'd0, 1'b1, 1'b0);
        run_instr(BNE, 6'd0, 1'b1, 1'b1);
        run_instr(6'b111111, 6'd0, 1'b0, 1'b0);

        // Reset in the middle of lw, landing in MEMWB where RegWrite would be set.
        bus.Op = LW;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_estado", 32'(bus.Estado), 32'd4);
        check("midreset_en", 32'(enables()), 32'd0);
        @(negedge clk);
        check("midreset_after", 32'(bus.Estado), 32'd0);
        reset = 1'b0;

        for (int n = 0; n < 80; n++) begin
            op = op_tbl[$urandom_range(0, 7)];
            if (op == 6'b111111) begin
                do op = 6'($urandom); while (is_known(op));
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 5)];
            run_instr(op, fn, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
